// File: rtl/sccb_target_regfile.sv
// sccb_target_regfile
//   SCCB/I2C target with a 2**MEM_AW byte register file and 16-bit register
//   addressing. It only ever pulls SDA low and never stretches SCL.
//   Write: START, {DEV_ADDR,0}, addr_hi, addr_lo, data... STOP.
//   Read:  START, {DEV_ADDR,1}, data... from the current pointer.
//   Bytes are written at the pointer, which then auto-increments.
// Ports
//   i_clk       system clock, at least 16x the SCL rate
//   i_rst       synchronous, active-low reset
//   i_scl_in    SCL pad input (asynchronous)
//   i_sda_in    SDA pad input (asynchronous)
//   o_sda_out   SDA drive value, always 0 (open drain)
//   o_sda_oe    1 = pull SDA low
//   o_wr_valid  one-cycle pulse per register byte written
//   o_wr_addr   register address of that write
//   o_wr_data   data of that write
//   o_busy      1 from the device-address ACK until STOP/START/NACK
module sccb_target_regfile #(
  parameter logic [6:0]  DEV_ADDR = 7'h60,
  parameter int unsigned MEM_AW   = 8,
  parameter logic [7:0]  RST_VAL  = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_scl_in,
  input  logic        i_sda_in,
  output logic        o_sda_out,
  output logic        o_sda_oe,
  output logic        o_wr_valid,
  output logic [15:0] o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_busy
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEV_ADDR = 3'd1,
    ST_ADDR_HI  = 3'd2,
    ST_ADDR_LO  = 3'd3,
    ST_WR_DATA  = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_ACK_OUT  = 3'd6,
    ST_ACK_IN   = 3'd7
  } state_t;

  logic [1:0]  scl_sync_r, sda_sync_r;
  logic        scl_hist_r, sda_hist_r;
  state_t      state_r, state_n;
  state_t      from_r, from_n;        // byte state whose ACK is being driven
  logic [3:0]  bit_cnt_r, bit_cnt_n;  // 0..8, 8 = all data bits seen
  logic [7:0]  shift_r, shift_n;
  logic [7:0]  addr_hi_r, addr_hi_n;
  logic [15:0] ptr_r, ptr_n;
  logic        oe_r, oe_n;
  logic        busy_r, busy_n;
  logic        wr_valid_r, wr_valid_n;
  logic [15:0] wr_addr_r, wr_addr_n;
  logic [7:0]  wr_data_r, wr_data_n;
  logic        mem_we_s;
  logic [7:0]  mem_r [0:DEPTH-1];

  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] rd_byte_s;

  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_s & ~scl_hist_r;
  assign scl_fall_s = ~scl_s & scl_hist_r;
  // Bus conditions need SCL high both before and after the SDA change.
  assign start_s    = scl_s & scl_hist_r & sda_hist_r & ~sda_s;
  assign stop_s     = scl_s & scl_hist_r & ~sda_hist_r & sda_s;
  assign rd_byte_s  = mem_r[ptr_r[MEM_AW-1:0]];

  assign o_sda_out  = 1'b0;
  assign o_sda_oe   = oe_r;
  assign o_wr_valid = wr_valid_r;
  assign o_wr_addr  = wr_addr_r;
  assign o_wr_data  = wr_data_r;
  assign o_busy     = busy_r;

  // Pad synchronisers plus history flops; reset to the idle-bus level.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], i_scl_in};
      sda_sync_r <= {sda_sync_r[0], i_sda_in};
      scl_hist_r <= scl_sync_r[1];
      sda_hist_r <= sda_sync_r[1];
    end
  end

  // Register file storage.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i[MEM_AW-1:0]] <= RST_VAL;
      end
    end else if (mem_we_s) begin
      mem_r[ptr_r[MEM_AW-1:0]] <= shift_r;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r    <= ST_IDLE;
      from_r     <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      addr_hi_r  <= 8'h00;
      ptr_r      <= 16'h0000;
      oe_r       <= 1'b0;
      busy_r     <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= 16'h0000;
      wr_data_r  <= 8'h00;
    end else begin
      state_r    <= state_n;
      from_r     <= from_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      addr_hi_r  <= addr_hi_n;
      ptr_r      <= ptr_n;
      oe_r       <= oe_n;
      busy_r     <= busy_n;
      wr_valid_r <= wr_valid_n;
      wr_addr_r  <= wr_addr_n;
      wr_data_r  <= wr_data_n;
    end
  end

  // Next-state logic: SCL rise samples SDA, SCL fall updates the SDA drive.
  always_comb begin
    state_n    = state_r;
    from_n     = from_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    addr_hi_n  = addr_hi_r;
    ptr_n      = ptr_r;
    oe_n       = oe_r;
    busy_n     = busy_r;
    wr_valid_n = 1'b0;
    wr_addr_n  = wr_addr_r;
    wr_data_n  = wr_data_r;
    mem_we_s   = 1'b0;
    if (stop_s) begin
      state_n   = ST_IDLE;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
    end else if (start_s) begin
      state_n   = ST_DEV_ADDR;
      bit_cnt_n = 4'd0;
      oe_n      = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_n = ST_IDLE;
        end
        ST_DEV_ADDR, ST_ADDR_HI, ST_ADDR_LO, ST_WR_DATA: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            shift_n   = {shift_r[6:0], sda_s};
            bit_cnt_n = bit_cnt_r + 4'd1;
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            if ((state_r == ST_DEV_ADDR) && (shift_r[7:1] != DEV_ADDR)) begin
              state_n = ST_IDLE;    // not us: stay off the bus
            end else begin
              state_n = ST_ACK_OUT;
              from_n  = state_r;
              oe_n    = 1'b1;
              busy_n  = (state_r == ST_DEV_ADDR) ? 1'b1 : busy_r;
            end
          end else begin
            bit_cnt_n = bit_cnt_r;
          end
        end
        ST_ACK_OUT: begin
          if (scl_rise_s) begin
            // The ACK-slot rise commits the byte just acknowledged.
            case (from_r)
              ST_ADDR_HI: addr_hi_n = shift_r;
              ST_ADDR_LO: ptr_n = {addr_hi_r, shift_r};
              ST_WR_DATA: begin
                mem_we_s   = 1'b1;
                wr_valid_n = 1'b1;
                wr_addr_n  = ptr_r;
                wr_data_n  = shift_r;
                ptr_n      = ptr_r + 16'd1;
              end
              default: ptr_n = ptr_r;
            endcase
          end else if (scl_fall_s) begin
            bit_cnt_n = 4'd0;
            oe_n      = 1'b0;
            case (from_r)
              ST_DEV_ADDR: begin
                if (shift_r[0]) begin
                  state_n = ST_RD_DATA;
                  shift_n = rd_byte_s;
                  oe_n    = ~rd_byte_s[7];
                end else begin
                  state_n = ST_ADDR_HI;
                end
              end
              ST_ADDR_HI: state_n = ST_ADDR_LO;
              default:    state_n = ST_WR_DATA;
            endcase
          end else begin
            oe_n = oe_r;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            bit_cnt_n = bit_cnt_r + 4'd1;
          end else if (scl_fall_s) begin
            if (bit_cnt_r == 4'd8) begin
              state_n = ST_ACK_IN;
              oe_n    = 1'b0;
              ptr_n   = ptr_r + 16'd1;
            end else begin
              shift_n = {shift_r[6:0], 1'b0};
              oe_n    = ~shift_r[6];
            end
          end else begin
            oe_n = oe_r;
          end
        end
        ST_ACK_IN: begin
          if (scl_rise_s) begin
            if (sda_s) begin
              state_n = ST_IDLE;    // master NACK ends the read
              busy_n  = 1'b0;
            end else begin
              state_n = ST_ACK_IN;
            end
          end else if (scl_fall_s) begin
            state_n   = ST_RD_DATA;
            bit_cnt_n = 4'd0;
            shift_n   = rd_byte_s;
            oe_n      = ~rd_byte_s[7];
          end else begin
            state_n = ST_ACK_IN;
          end
        end
        default: begin
          state_n = ST_IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_target_regfile.sv
// Bench: bit-banged SCCB master with a scoreboard. Expected values are pushed
// when a transaction is issued; a monitor pops and compares whenever the DUT
// presents a write pulse or the master reports an observed value.
module tb_sccb_target_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_out, sda_oe, wr_valid, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        sda_line;

  assign sda_line = m_sda & ~sda_oe;

  sccb_target_regfile dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_scl_in   (m_scl),
    .i_sda_in   (sda_line),
    .o_sda_out  (sda_out),
    .o_sda_oe   (sda_oe),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          oe_cnt = 0;
  logic [23:0] wr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       obs_n[$];
  logic [23:0] mon_w;
  logic [31:0] mon_e, mon_a;
  string       mon_s;

  // Scoreboard monitor: the only process that compares and counts.
  always @(negedge clk) begin
    if (sda_oe) oe_cnt++;
    if (wr_valid) begin
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL wr_unexpected: got addr=0x%04h data=0x%02h, required no write", wr_addr, wr_data);
      end else begin
        mon_w = wr_q.pop_front();
        if ({wr_addr, wr_data} !== mon_w) begin
          n_bad++;
          $display("FAIL wr: got addr=0x%04h data=0x%02h, required addr=0x%04h data=0x%02h",
                   wr_addr, wr_data, mon_w[23:8], mon_w[7:0]);
        end
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      mon_a = obs_q.pop_front();
      mon_s = obs_n.pop_front();
      mon_e = exp_q.pop_front();
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, required 0x%0h", mon_s, mon_a, mon_e);
      end
    end
  end

  task automatic expect_val(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic report(input string nm, input logic [31:0] a);
    obs_n.push_back(nm);
    obs_q.push_back(a);
  endtask

  task automatic observe(input string nm, input logic [31:0] a, input logic [31:0] e);
    expect_val(e);
    report(nm, a);
  endtask

  task automatic q();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic bit_io(input logic b, output logic s);
    m_sda = b; q();
    m_scl = 1'b1; q();
    s = sda_line; q();
    m_scl = 1'b0; q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    m_sda = 1'b0; q();
    m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q();
    m_scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask

  // Send a byte and report whether the target acknowledged it.
  task automatic wr(input string nm, input logic [7:0] d, input logic exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(d[i], s);
    bit_io(1'b1, s);
    observe(nm, {31'd0, ~s}, {31'd0, exp_ack});
  endtask

  // Read a byte, then send ACK (send_ack=1) or NACK.
  task automatic rd(input string nm, input logic send_ack, input logic [7:0] exp_d);
    logic s;
    logic [7:0] d;
    expect_val({24'd0, exp_d});
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(~send_ack, s);
    report(nm, {24'd0, d});
  endtask

  initial begin
    logic s;
    int   oe_snap;
    // Reset values
    repeat (4) @(posedge clk);
    #1;
    observe("rst_oe", {31'd0, sda_oe}, 32'd0);
    observe("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    observe("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
    observe("rst_wr_data", {24'd0, wr_data}, 32'd0);
    observe("rst_busy", {31'd0, busy}, 32'd0);
    observe("rst_sda_out", {31'd0, sda_out}, 32'd0);
    rst_n = 1'b1;
    q();

    // Preload mem[0x03]=0x3C for the pointer check later
    wr_q.push_back({16'h0003, 8'h3C});
    i2c_start();
    wr("t0_dev", 8'hC0, 1'b1);
    wr("t0_hi", 8'h00, 1'b1);
    wr("t0_lo", 8'h03, 1'b1);
    wr("t0_d", 8'h3C, 1'b1);
    i2c_stop();

    // Test 1: single write 0xA5 to 0x0100
    wr_q.push_back({16'h0100, 8'hA5});
    i2c_start();
    wr("t1_dev_ack", 8'hC0, 1'b1);
    observe("t1_busy_on", {31'd0, busy}, 32'd1);
    wr("t1_hi_ack", 8'h01, 1'b1);
    wr("t1_lo_ack", 8'h00, 1'b1);
    wr("t1_data_ack", 8'hA5, 1'b1);
    i2c_stop();
    observe("t1_busy_off", {31'd0, busy}, 32'd0);

    // Test 2: random read at 0x3500 (aliases to 0x00), 3 bytes
    i2c_start();
    wr("t2_dev", 8'hC0, 1'b1);
    wr("t2_hi", 8'h35, 1'b1);
    wr("t2_lo", 8'h00, 1'b1);
    i2c_start();
    wr("t2_devr", 8'hC1, 1'b1);
    rd("t2_rd0", 1'b1, 8'hA5);
    rd("t2_rd1", 1'b1, 8'h00);
    rd("t2_rd2", 1'b0, 8'h00);
    observe("t2_busy_nack", {31'd0, busy}, 32'd0);
    i2c_stop();
    // Plain read continues at 0x3503 -> mem[0x03]
    i2c_start();
    wr("t2_devr2", 8'hC1, 1'b1);
    rd("t2_ptr_3503", 1'b0, 8'h3C);
    i2c_stop();

    // Test 3: foreign address is ignored, next START to us is ACKed
    oe_snap = oe_cnt;
    i2c_start();
    wr("t3_nack", 8'h84, 1'b0);
    observe("t3_busy", {31'd0, busy}, 32'd0);
    observe("t3_oe_cycles", oe_cnt - oe_snap, 32'd0);

    // Test 4: burst write wrapping the pointer FFFF -> 0000
    wr_q.push_back({16'hFFFF, 8'h11});
    wr_q.push_back({16'h0000, 8'h22});
    i2c_start();
    wr("t4_dev_ack", 8'hC0, 1'b1);
    wr("t4_hi", 8'hFF, 1'b1);
    wr("t4_lo", 8'hFF, 1'b1);
    wr("t4_d0", 8'h11, 1'b1);
    wr("t4_d1", 8'h22, 1'b1);
    i2c_stop();

    // Test 5: STOP after 4 data bits, no write
    i2c_start();
    wr("t5_dev", 8'hC0, 1'b1);
    wr("t5_hi", 8'h00, 1'b1);
    wr("t5_lo", 8'h10, 1'b1);
    bit_io(1'b1, s);
    bit_io(1'b0, s);
    bit_io(1'b1, s);
    bit_io(1'b1, s);
    i2c_stop();
    observe("t5_busy", {31'd0, busy}, 32'd0);
    observe("t5_oe", {31'd0, sda_oe}, 32'd0);
    observe("t5_wr_pending", wr_q.size(), 32'd0);

    // Test 6: reset while target drives bit 7 of mem[0x00]=0x22 (a 0)
    i2c_start();
    wr("t6_dev", 8'hC0, 1'b1);
    wr("t6_hi", 8'h00, 1'b1);
    wr("t6_lo", 8'h00, 1'b1);
    i2c_start();
    wr("t6_devr", 8'hC1, 1'b1);
    m_sda = 1'b1; q();
    m_scl = 1'b1; q();
    observe("t6_bit7_low", {31'd0, sda_line}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    observe("t6_oe_released", {31'd0, sda_oe}, 32'd0);
    observe("t6_busy", {31'd0, busy}, 32'd0);
    observe("t6_wr_addr", {16'd0, wr_addr}, 32'd0);
    observe("t6_wr_data", {24'd0, wr_data}, 32'd0);
    observe("t6_wr_valid", {31'd0, wr_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    q();
    m_scl = 1'b0; q();
    i2c_stop();
    // Pointer back to 0, registers back to 0x00
    i2c_start();
    wr("t6_devr2", 8'hC1, 1'b1);
    rd("t6_mem0_reset", 1'b1, 8'h00);
    rd("t6_mem1_reset", 1'b0, 8'h00);
    i2c_stop();

    repeat (20) @(posedge clk);
    #1;
    observe("wr_pending", wr_q.size(), 32'd0);
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
